// File: rtl/color_cmd_pkg.sv
// color_cmd_pkg: shared types and constants for the Color/HSV command sequencer
package color_cmd_pkg;
  localparam int CMD_W = 2;
  localparam logic [CMD_W-1:0] CMD_NEUTRAL = 2'h3;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_HOLD, SEQ_GAP} seq_state_t;
  function automatic int entry_w(int hold_w);
    return CMD_W + hold_w;
  endfunction
endpackage

// File: rtl/color_cmd_sequencer_if.sv
// color_cmd_sequencer_if: valid/ready request bus carrying timed commands
interface color_cmd_sequencer_if #(parameter int HOLD_W = 4);
  import color_cmd_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [CMD_W-1:0] req_cmd;
  logic [HOLD_W-1:0] req_hold;
  modport master(output req_valid, req_cmd, req_hold, input req_ready);
  modport slave(input req_valid, req_cmd, req_hold, output req_ready);
endinterface

// File: rtl/color_cmd_fifo.sv
// color_cmd_fifo: synchronous FIFO with flush, no bypass between pop and push
module color_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok = pop && !empty && !flush;
  // pointer and occupancy update; flush discards everything
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(push_ok);
    rd_d = flush ? '0 : rd_q + AW'(pop_ok);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  // pointer/count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/color_cmd_sequencer.sv
// color_cmd_sequencer: buffers timed commands and replays them on the Color FSM input stream
module color_cmd_sequencer
  import color_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD_W = 4,
  parameter int GAP_CYCLES = 1,
  parameter logic [CMD_W-1:0] IDLE_CMD = CMD_NEUTRAL
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  color_cmd_sequencer_if.slave req,
  output logic [CMD_W-1:0] cmd_out,
  output logic cmd_active,
  output logic busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [HOLD_W-1:0] hold;
  } cmd_entry_t;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  cmd_entry_t head;
  logic full, empty, push, pop;
  seq_state_t state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic active_q, active_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  assign req.req_ready = !full && !rst && !flush;
  assign push = req.req_valid && req.req_ready;
  assign cmd_out = cmd_q;
  assign cmd_active = active_q;
  assign busy = (fifo_count != '0) || (state_q != SEQ_IDLE);
  color_cmd_fifo #(.DEPTH(DEPTH), .W(entry_w(HOLD_W))) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(push),
    .pop(pop),
    .din({req.req_cmd, req.req_hold}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  // playback FSM: load from FIFO, hold for hold+1 cycles, then optional neutral gap
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    active_d = active_q;
    hold_d = hold_q;
    gap_d = gap_q;
    pop = 1'b0;
    case (state_q)
      SEQ_IDLE: pop = !empty;
      SEQ_HOLD:
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        else if (GAP_CYCLES > 0) begin
          cmd_d = IDLE_CMD;
          active_d = 1'b0;
          gap_d = GAP_INIT;
          state_d = SEQ_GAP;
        end else if (!empty) pop = 1'b1;
        else begin
          cmd_d = IDLE_CMD;
          active_d = 1'b0;
          state_d = SEQ_IDLE;
        end
      SEQ_GAP:
        if (gap_q != '0) gap_d = gap_q - GW'(1);
        else if (!empty) pop = 1'b1;
        else state_d = SEQ_IDLE;
      default: state_d = SEQ_IDLE;
    endcase
    if (pop) begin
      cmd_d = head.cmd;
      hold_d = head.hold;
      active_d = 1'b1;
      state_d = SEQ_HOLD;
    end
    if (flush) begin
      pop = 1'b0;
      state_d = SEQ_IDLE;
      cmd_d = IDLE_CMD;
      active_d = 1'b0;
    end
  end
  // FSM and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      cmd_q <= IDLE_CMD;
      active_q <= 1'b0;
      hold_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      active_q <= active_d;
      hold_q <= hold_d;
      gap_q <= gap_d;
    end
  end
endmodule
